// File: rtl/cpu_boot_sequencer.sv
// Boot sequencer: streams a program into CPU instruction memory, waits a settle gap, then
// enables the program counter. Supports halt/resume and reload while running.
module cpu_boot_sequencer #(
   parameter int unsigned ADDR_W        = 3,
   parameter int unsigned DATA_W        = 17,
   parameter int unsigned DEPTH         = 8,
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   input  logic              halt,
   input  logic              resume,
   output logic [ADDR_W-1:0] wr,
   output logic [DATA_W-1:0] wrd,
   output logic              we,
   output logic              pc_en,
   output logic              busy,
   output logic [ADDR_W:0]   word_count,
   output logic              err_trunc
);

   localparam int unsigned CntW = ADDR_W + 1;
   localparam logic [CntW-1:0] DepthC  = CntW'(DEPTH);
   localparam logic [CntW-1:0] LastC   = CntW'(DEPTH - 1);
   localparam logic [3:0]      SettleC = 4'(SETTLE_CYCLES);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StSettle,
      StRun,
      StHalt
   } state_e;

   state_e          state;
   logic [CntW-1:0] addr;
   logic [3:0]      settle_cnt;
   logic            xfer;
   logic            last_slot;

   always_comb begin
      in_ready  = (state == StLoad) && (addr < DepthC);
      busy      = (state == StLoad) || (state == StSettle);
      xfer      = in_valid && in_ready;
      last_slot = (addr == LastC);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= StIdle;
         addr       <= '0;
         settle_cnt <= '0;
         wr         <= '0;
         wrd        <= '0;
         we         <= 1'b0;
         pc_en      <= 1'b0;
         word_count <= '0;
         err_trunc  <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (start) begin
                  state      <= StLoad;
                  addr       <= '0;
                  word_count <= '0;
                  err_trunc  <= 1'b0;
               end
            end

            StLoad: begin
               if (xfer) begin
                  wr   <= addr[ADDR_W-1:0];
                  wrd  <= in_data;
                  we   <= 1'b1;
                  addr <= addr + 1'b1;
                  if (word_count != DepthC) begin
                     word_count <= word_count + 1'b1;
                  end
                  // Memory full without a terminating word still proceeds to run.
                  if (in_last || last_slot) begin
                     state      <= StSettle;
                     settle_cnt <= '0;
                  end
                  if (!in_last && last_slot) begin
                     err_trunc <= 1'b1;
                  end
               end else begin
                  we <= 1'b0;
               end
            end

            StSettle: begin
               we <= 1'b0;
               // First edge here retires the last write; SETTLE_CYCLES quiet cycles follow.
               if (settle_cnt == SettleC) begin
                  pc_en <= 1'b1;
                  state <= StRun;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end

            StRun: begin
               if (start) begin
                  state      <= StLoad;
                  pc_en      <= 1'b0;
                  addr       <= '0;
                  word_count <= '0;
                  err_trunc  <= 1'b0;
               end else if (halt) begin
                  state <= StHalt;
                  pc_en <= 1'b0;
               end
            end

            StHalt: begin
               if (start) begin
                  state      <= StLoad;
                  pc_en      <= 1'b0;
                  addr       <= '0;
                  word_count <= '0;
                  err_trunc  <= 1'b0;
               end else if (resume) begin
                  state <= StRun;
                  pc_en <= 1'b1;
               end
            end

            default: begin
               state <= StIdle;
               we    <= 1'b0;
               pc_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_boot_sequencer.sv
// Self-checking bench for cpu_boot_sequencer: a cycle model compared every cycle plus directed
// literal checks for load, backpressure, truncation, halt/resume, reload and reset.
module tb_cpu_boot_sequencer;

   localparam int unsigned ADDR_W        = 3;
   localparam int unsigned DATA_W        = 17;
   localparam int unsigned DEPTH         = 8;
   localparam int unsigned SETTLE_CYCLES = 1;
   localparam int unsigned CW            = ADDR_W + 1;

   logic              clk = 1'b0;
   logic              rst, start, in_valid, in_last, halt, resume;
   logic              in_ready, we, pc_en, busy, err_trunc;
   logic [DATA_W-1:0] in_data, wrd;
   logic [ADDR_W-1:0] wr;
   logic [ADDR_W:0]   word_count;

   always #5 clk = ~clk;

   cpu_boot_sequencer #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .DEPTH        (DEPTH),
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .halt      (halt),
      .resume    (resume),
      .wr        (wr),
      .wrd       (wrd),
      .we        (we),
      .pc_en     (pc_en),
      .busy      (busy),
      .word_count(word_count),
      .err_trunc (err_trunc)
   );

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
   endtask

   // Behavioural model: phase flags plus a word counter and a settle countdown.
   bit                m_ld, m_st, m_run, m_hlt, m_trunc;
   int                m_cnt, m_left;
   logic [ADDR_W-1:0] e_wr;
   logic [DATA_W-1:0] e_wrd;
   bit                e_we, e_pc;

   always @(posedge clk) begin
      if (rst) begin
         m_ld = 0; m_st = 0; m_run = 0; m_hlt = 0; m_trunc = 0;
         m_cnt = 0; m_left = 0;
         e_wr = '0; e_wrd = '0; e_we = 0; e_pc = 0;
      end else if (m_ld) begin
         if (in_valid && m_cnt < DEPTH) begin
            e_wr  = ADDR_W'(m_cnt);
            e_wrd = in_data;
            e_we  = 1;
            m_cnt++;
            if (in_last || m_cnt == DEPTH) begin
               m_ld   = 0;
               m_st   = 1;
               m_left = SETTLE_CYCLES;
               if (!in_last) m_trunc = 1;
            end
         end else begin
            e_we = 0;
         end
      end else if (m_st) begin
         e_we = 0;
         if (m_left == 0) begin
            m_st = 0; m_run = 1; e_pc = 1;
         end else begin
            m_left--;
         end
      end else if (start) begin
         m_ld = 1; m_run = 0; m_hlt = 0; e_pc = 0; m_cnt = 0; m_trunc = 0;
      end else if (m_run && halt) begin
         m_run = 0; m_hlt = 1; e_pc = 0;
      end else if (m_hlt && resume) begin
         m_hlt = 0; m_run = 1; e_pc = 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic exp_rdy, exp_busy;
         exp_rdy  = m_ld && (m_cnt < DEPTH);
         exp_busy = m_ld || m_st;
         n_checks++;
         if ({in_ready, busy, we, pc_en, err_trunc, wr, wrd, word_count} ===
             {exp_rdy, exp_busy, e_we, e_pc, m_trunc, e_wr, e_wrd, CW'(m_cnt)}) begin
            n_pass++;
         end else begin
            $display("FAIL model t=%0t: got rdy=%b busy=%b we=%b pc_en=%b trunc=%b wr=%0d wrd=%h cnt=%0d, expected rdy=%b busy=%b we=%b pc_en=%b trunc=%b wr=%0d wrd=%h cnt=%0d",
                     $time, in_ready, busy, we, pc_en, err_trunc, wr, wrd, word_count,
                     exp_rdy, exp_busy, e_we, e_pc, m_trunc, e_wr, e_wrd, m_cnt);
         end
      end
   end

   // Mirror of CPU instruction memory and an ordered log of written addresses.
   logic [DATA_W-1:0] mem [DEPTH];
   int                wlog [$];

   always @(posedge clk) begin
      if (chk_en && we === 1'b1) begin
         mem[wr] = wrd;
         wlog.push_back(int'(wr));
      end
   end

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic send(input logic [DATA_W-1:0] d, input bit last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      cycle();
   endtask

   task automatic wait_run(input string name);
      int n = 0;
      while (pc_en !== 1'b1 && n < 20) begin
         cycle();
         n++;
      end
      check(name, pc_en, 1);
   endtask

   task automatic check_log(input string name, input int n_exp);
      check({name, "_len"}, wlog.size(), n_exp);
      for (int i = 0; i < n_exp && i < wlog.size(); i++) check({name, "_addr"}, wlog[i], i);
   endtask

   logic [DATA_W-1:0] prog [4];

   initial begin
      prog[0] = 17'h0A050; prog[1] = 17'h0A440; prog[2] = 17'h02080; prog[3] = 17'h10000;
      rst = 1; start = 0; in_valid = 0; in_data = '0; in_last = 0; halt = 0; resume = 0;
      cycle();
      chk_en = 1;
      check("rst_we", we, 0);
      check("rst_pc_en", pc_en, 0);
      check("rst_count", word_count, 0);
      check("rst_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      rst = 0;
      cycle();
      check("idle_ready", in_ready, 0);

      // Basic load and run
      start = 1; cycle(); start = 0;
      check("b_busy", busy, 1);
      check("b_ready", in_ready, 1);
      wlog.delete();
      send(prog[0], 0);
      check("b_we0", we, 1); check("b_wr0", wr, 0); check("b_wrd0", wrd, 17'h0A050);
      send(prog[1], 0);
      send(prog[2], 0);
      send(prog[3], 1);
      check("b_we3", we, 1); check("b_wr3", wr, 3); check("b_wrd3", wrd, 17'h10000);
      in_valid = 0;
      cycle();
      check("b_gap_we", we, 0); check("b_gap_pc", pc_en, 0);
      cycle();
      check("b_pc_en", pc_en, 1); check("b_run_busy", busy, 0);
      check("b_count", word_count, 4); check("b_trunc", err_trunc, 0);
      cycle();
      check_log("b_log", 4);
      check("b_mem0", mem[0], 17'h0A050); check("b_mem1", mem[1], 17'h0A440);
      check("b_mem2", mem[2], 17'h02080); check("b_mem3", mem[3], 17'h10000);

      // Reload from RUN with backpressure gaps; start/halt in LOAD are ignored
      start = 1; cycle(); start = 0;
      check("r_pc0", pc_en, 0); check("r_count0", word_count, 0); check("r_busy", busy, 1);
      wlog.delete();
      for (int i = 0; i < 4; i++) begin
         send(prog[i], i == 3);
         if (i < 3) begin
            in_valid = 0; in_data = 17'h1FFFF; in_last = 1;
            start = (i == 1); halt = (i == 2);
            cycle();
            start = 0; halt = 0;
            check("bp_gap_we", we, 0); check("bp_gap_wr", wr, i); check("bp_gap_wrd", wrd, prog[i]);
         end
      end
      in_valid = 0;
      wait_run("bp_run");
      cycle();
      check_log("bp_log", 4);
      check("bp_mem2", mem[2], 17'h02080);

      // Halt / resume
      halt = 1; cycle();
      check("h_pc0", pc_en, 0);
      cycle(); cycle();
      check("h_pc_held", pc_en, 0);
      halt = 0; resume = 1; cycle(); resume = 0;
      check("h_resume", pc_en, 1);
      cycle();
      check("h_run", pc_en, 1);
      halt = 1; resume = 1; cycle(); halt = 0; resume = 0;
      check("hr_both", pc_en, 0);
      cycle();
      check("hr_stay", pc_en, 0);
      resume = 1; cycle(); resume = 0;
      check("hr_resume", pc_en, 1);

      // Truncation: nine words, no in_last
      start = 1; cycle(); start = 0;
      wlog.delete();
      for (int i = 0; i < 9; i++) begin
         send(DATA_W'(17'h00100 + i), 0);
         if (i == 7) begin
            check("t_ready", in_ready, 0); check("t_trunc", err_trunc, 1);
            check("t_count", word_count, 8); check("t_wr7", wr, 7);
         end
      end
      in_valid = 0;
      wait_run("t_run");
      cycle();
      check_log("t_log", 8);
      check("t_mem7", mem[7], 17'h00107);
      check("t_count_run", word_count, 8);

      // Reload a 2-word program from RUN
      start = 1; cycle(); start = 0;
      check("r2_trunc", err_trunc, 0); check("r2_count", word_count, 0); check("r2_pc", pc_en, 0);
      wlog.delete();
      send(17'h1ABCD, 0);
      send(17'h00777, 1);
      in_valid = 0;
      wait_run("r2_run");
      cycle();
      check_log("r2_log", 2);
      check("r2_mem0", mem[0], 17'h1ABCD); check("r2_mem1", mem[1], 17'h00777);
      check("r2_count_run", word_count, 2);

      // Reset mid-load
      start = 1; cycle(); start = 0;
      send(17'h00AAA, 0);
      send(17'h00BBB, 0);
      rst = 1; in_data = 17'h00CCC; cycle(); rst = 0;
      check("mr_we", we, 0); check("mr_wr", wr, 0); check("mr_wrd", wrd, 0);
      check("mr_count", word_count, 0); check("mr_busy", busy, 0);
      check("mr_ready", in_ready, 0); check("mr_pc", pc_en, 0);
      repeat (3) cycle();
      check("mr_idle_we", we, 0); check("mr_idle_count", word_count, 0);
      check("mr_idle_ready", in_ready, 0);
      in_valid = 0;
      cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
